pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//   Control path of the 5-stage pipelined RV32 core that supersedes the single-cycle CPU top.
//   Holds the IF/ID instruction/PC register and the ID/EX, EX/MEM, MEM/WB control and rd registers.
//   Decodes main control, detects load-use hazards (stall), applies branch flush and drives EX forwarding selects.
//   Datapath values (register data, ALU results) live outside this block.
// PARAMETERS
//   XLEN       32  PC / address width
//   RA_W       5   register-address width
//   CNT_W      16  width of the saturating stall/flush event counters
// PORTS
//   clk_i          in   1      clock, all state updates on rising edge
//   rst_i          in   1      synchronous, active-high reset
//   start_i        in   1      1 = pipeline advances; 0 = every register holds, pc_write_o=0
//   if_pc_i        in   XLEN   PC of the instruction being fetched
//   if_instr_i     in   32     fetched instruction
//   id_branch_i    in   1      beq in ID resolved taken (datapath comparator)
//   pc_write_o     out  1      PC register enable
//   ifid_pc_o      out  XLEN   IF/ID PC
//   ifid_instr_o   out  32     IF/ID instruction (decode source for rs1=[19:15], rs2=[24:20], rd=[11:7])
//   ex_ctrl_o      out  7      ID/EX {ALUSrc,ALUOp[1:0],MemRead,MemWrite,RegWrite,MemToReg}
//   ex_fwd_a_o     out  2      ALU operand A select: 00 reg, 10 EX/MEM result, 01 MEM/WB data
//   ex_fwd_b_o     out  2      same for operand B (before ALUSrc mux)
//   mem_rd_o/mem_ctrl_o out RA_W/4  EX/MEM rd and {MemRead,MemWrite,RegWrite,MemToReg}
//   wb_rd_o        out  RA_W   MEM/WB rd
//   wb_regwrite_o  out  1      MEM/WB RegWrite;  wb_memtoreg_o out 1  MEM/WB MemToReg
//   stall_o        out  1      load-use stall active this cycle (combinational)
//   flush_o        out  1      IF/ID flush requested this cycle (combinational)
//   stall_cnt_o    out  CNT_W  stall cycles since reset;  flush_cnt_o out CNT_W  flushes since reset
// BEHAVIOUR
//   Reset (rst_i=1 at edge): IF/ID = {PC 0, instr 32'h00000013 NOP}; all ctrl/rd regs 0; counters 0.
//     Hence after reset: ex_ctrl_o=0, mem_ctrl_o=0, wb_regwrite_o=0, fwd selects 00, pc_write_o=start_i.
//   Decode (opcode [6:0]) -> {ALUSrc,ALUOp,MR,MW,RW,M2R}: 0110011 R ->0_10_0010; 0010011 I ->1_11_0010;
//     0000011 LW ->1_00_1011; 0100011 SW ->1_00_0100; 1100011 BEQ ->0_01_0000; other ->all 0.
//   Load-use: stall_o = ex MemRead & ex_rd!=0 & (ex_rd==ifid rs1 | ex_rd==ifid rs2).
//     On stall: pc_write_o=0, IF/ID holds, ID/EX ctrl loaded with 0 (bubble); EX/MEM, MEM/WB advance.
//   Flush: flush_o = id_branch_i & ~stall_o. Next edge IF/ID <= {if_pc_i, NOP}; ID/EX takes the branch normally.
//     Stall has priority; a taken branch waiting on a load-use resolves the following cycle.
//   Forwarding A (B identical with rs2): 10 if mem RegWrite & mem_rd!=0 & mem_rd==ex_rs1;
//     else 01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1; else 00. EX/MEM wins over MEM/WB.
//     ex_rs1/ex_rs2 are latched in ID/EX alongside ex_rd.
//   Normal advance: IF/ID<=if inputs, ID/EX<=decode(IF/ID), EX/MEM<=ID/EX, MEM/WB<=EX/MEM; latency 1 cycle/stage.
//   start_i=0: no register changes, counters hold, pc_write_o=0; stall_o/flush_o still reflect current state.
//   Counters: +1 per advancing cycle with stall_o (resp. flush_o); saturate at all-ones, no wrap.
//   Reset mid-stall or mid-flush: reset wins, pipeline returns to all-NOP state in one edge.
// TESTING
//   1 Reset, start_i=1, feed addi x1,x0,5 then add x2,x1,x1 -> cycle of add in EX: ex_fwd_a_o=ex_fwd_b_o=10.
//   2 addi x1; nop; add x2,x1,x0 -> add in EX: ex_fwd_a_o=01, ex_fwd_b_o=00 (rs2=x0 never forwarded).
//   3 lw x3,0(x0); add x4,x3,x0 -> one cycle stall_o=1, pc_write_o=0, ex_ctrl_o=0, then ex_fwd_a_o=01; stall_cnt_o=1.
//   4 beq in IF/ID with id_branch_i=1 -> next cycle ifid_instr_o=32'h00000013, flush_cnt_o=1.
//   5 lw x5 in EX, beq x5,x0 in ID with id_branch_i=1 -> flush_o=0, stall_o=1; next cycle flush_o=1.
//   6 start_i=0 for 3 cycles mid-stream -> all outputs unchanged, counters unchanged; rst_i=1 mid-stall -> all-NOP state.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - fetch inputs and pipeline control outputs of the hazard controller
// The master side feeds fetched instructions; the slave side is the controller itself.
interface pipeline_hazard_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic             start_i;
  logic [XLEN-1:0]  if_pc_i;
  logic [31:0]      if_instr_i;
  logic             id_branch_i;
  logic             pc_write_o;
  logic [XLEN-1:0]  ifid_pc_o;
  logic [31:0]      ifid_instr_o;
  logic [6:0]       ex_ctrl_o;
  logic [1:0]       ex_fwd_a_o;
  logic [1:0]       ex_fwd_b_o;
  logic [RA_W-1:0]  mem_rd_o;
  logic [3:0]       mem_ctrl_o;
  logic [RA_W-1:0]  wb_rd_o;
  logic             wb_regwrite_o;
  logic             wb_memtoreg_o;
  logic             stall_o;
  logic             flush_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output start_i, if_pc_i, if_instr_i, id_branch_i,
    input  pc_write_o, ifid_pc_o, ifid_instr_o, ex_ctrl_o, ex_fwd_a_o, ex_fwd_b_o,
    input  mem_rd_o, mem_ctrl_o, wb_rd_o, wb_regwrite_o, wb_memtoreg_o,
    input  stall_o, flush_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  start_i, if_pc_i, if_instr_i, id_branch_i,
    output pc_write_o, ifid_pc_o, ifid_instr_o, ex_ctrl_o, ex_fwd_a_o, ex_fwd_b_o,
    output mem_rd_o, mem_ctrl_o, wb_rd_o, wb_regwrite_o, wb_memtoreg_o,
    output stall_o, flush_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage RV32 control path: decode, load-use stall, branch flush, forwarding
// Holds IF/ID and the per-stage control/rd registers; datapath values live elsewhere.
module pipeline_hazard_ctrl #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input logic                  clk_i,
  input logic                  rst_i,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam logic [31:0] NOP = 32'h00000013;

  logic [XLEN-1:0]  ifid_pc;
  logic [31:0]      ifid_instr;
  logic [6:0]       ex_ctrl;
  logic [RA_W-1:0]  ex_rd, ex_rs1, ex_rs2;
  logic [3:0]       mem_ctrl;
  logic [RA_W-1:0]  mem_rd;
  logic             wb_regwrite, wb_memtoreg;
  logic [RA_W-1:0]  wb_rd;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic [6:0]       id_ctrl;
  logic [RA_W-1:0]  id_rd, id_rs1, id_rs2;
  logic             stall, flush;
  logic [1:0]       fwd_a, fwd_b;

  assign id_rd  = RA_W'(ifid_instr[11:7]);
  assign id_rs1 = RA_W'(ifid_instr[19:15]);
  assign id_rs2 = RA_W'(ifid_instr[24:20]);

  // {ALUSrc, ALUOp[1:0], MemRead, MemWrite, RegWrite, MemToReg}
  always_comb begin
    id_ctrl = 7'b0000000;
    case (ifid_instr[6:0])
      7'b0110011: id_ctrl = 7'b0100010;
      7'b0010011: id_ctrl = 7'b1110010;
      7'b0000011: id_ctrl = 7'b1001011;
      7'b0100011: id_ctrl = 7'b1000100;
      7'b1100011: id_ctrl = 7'b0010000;
      default:    id_ctrl = 7'b0000000;
    endcase
  end

  assign stall = ex_ctrl[3] && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign flush = bus.id_branch_i && !stall;

  // The younger EX/MEM result takes precedence over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    if (mem_ctrl[1] && (mem_rd != '0) && (mem_rd == ex_rs1))
      fwd_a = 2'b10;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs1))
      fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (mem_ctrl[1] && (mem_rd != '0) && (mem_rd == ex_rs2))
      fwd_b = 2'b10;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs2))
      fwd_b = 2'b01;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ifid_pc     <= '0;
      ifid_instr  <= NOP;
      ex_ctrl     <= '0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      mem_ctrl    <= '0;
      mem_rd      <= '0;
      wb_regwrite <= 1'b0;
      wb_memtoreg <= 1'b0;
      wb_rd       <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else if (bus.start_i) begin
      mem_ctrl    <= ex_ctrl[3:0];
      mem_rd      <= ex_rd;
      wb_regwrite <= mem_ctrl[1];
      wb_memtoreg <= mem_ctrl[0];
      wb_rd       <= mem_rd;
      if (stall) begin
        // Bubble carries no register names so it can never trigger forwarding.
        ex_ctrl <= '0;
        ex_rd   <= '0;
        ex_rs1  <= '0;
        ex_rs2  <= '0;
      end else begin
        ex_ctrl    <= id_ctrl;
        ex_rd      <= id_rd;
        ex_rs1     <= id_rs1;
        ex_rs2     <= id_rs2;
        ifid_pc    <= bus.if_pc_i;
        ifid_instr <= flush ? NOP : bus.if_instr_i;
      end
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_write_o    = bus.start_i && !stall;
  assign bus.ifid_pc_o     = ifid_pc;
  assign bus.ifid_instr_o  = ifid_instr;
  assign bus.ex_ctrl_o     = ex_ctrl;
  assign bus.ex_fwd_a_o    = fwd_a;
  assign bus.ex_fwd_b_o    = fwd_b;
  assign bus.mem_rd_o      = mem_rd;
  assign bus.mem_ctrl_o    = mem_ctrl;
  assign bus.wb_rd_o       = wb_rd;
  assign bus.wb_regwrite_o = wb_regwrite;
  assign bus.wb_memtoreg_o = wb_memtoreg;
  assign bus.stall_o       = stall;
  assign bus.flush_o       = flush;
  assign bus.stall_cnt_o   = stall_cnt;
  assign bus.flush_cnt_o   = flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and random checks of pipeline_hazard_ctrl against an instruction-tracking model
// The model tracks whole instruction words per stage and derives controls from them.
module tb_pipeline_hazard_ctrl;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if bus ();
  pipeline_hazard_ctrl dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_cmp = 0;
  int n_mis = 0;

  // Model: instruction word held in each stage; 0 marks a bubble.
  logic [31:0] m_ifid_pc, m_ifid, m_ex, m_mem, m_wb;
  int          m_scnt, m_fcnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    enc = {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), op};
  endfunction

  function automatic logic [6:0] m_ctrl(input logic [31:0] w);
    case (w[6:0])
      7'h33:   m_ctrl = 7'b0100010;
      7'h13:   m_ctrl = 7'b1110010;
      7'h03:   m_ctrl = 7'b1001011;
      7'h23:   m_ctrl = 7'b1000100;
      7'h63:   m_ctrl = 7'b0010000;
      default: m_ctrl = 7'b0000000;
    endcase
  endfunction

  function automatic int f_rd(input logic [31:0] w);  return int'(w[11:7]);  endfunction
  function automatic int f_rs1(input logic [31:0] w); return int'(w[19:15]); endfunction
  function automatic int f_rs2(input logic [31:0] w); return int'(w[24:20]); endfunction

  function automatic bit writes(input logic [31:0] w);
    logic [6:0] c;
    c = m_ctrl(w);
    return c[1] && f_rd(w) != 0;
  endfunction

  function automatic bit m_stall();
    logic [6:0] c;
    c = m_ctrl(m_ex);
    return c[3] && f_rd(m_ex) != 0 && (f_rd(m_ex) == f_rs1(m_ifid) || f_rd(m_ex) == f_rs2(m_ifid));
  endfunction

  function automatic logic [1:0] m_fwd(input int src);
    if (writes(m_mem) && f_rd(m_mem) == src) return 2'b10;
    if (writes(m_wb) && f_rd(m_wb) == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_ifid_pc = '0; m_ifid = NOP; m_ex = '0; m_mem = '0; m_wb = '0;
    m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic model_update();
    bit s, f;
    if (rst) begin
      model_reset();
    end else if (bus.start_i) begin
      s = m_stall();
      f = bus.id_branch_i && !s;
      if (s && m_scnt < 65535) m_scnt++;
      if (f && m_fcnt < 65535) m_fcnt++;
      m_wb  = m_mem;
      m_mem = m_ex;
      if (s) begin
        m_ex = '0;
      end else begin
        m_ex      = m_ifid;
        m_ifid_pc = bus.if_pc_i;
        m_ifid    = f ? NOP : bus.if_instr_i;
      end
    end
  endtask

  task automatic check_all();
    bit s;
    logic [6:0] c;
    s = m_stall();
    c = m_ctrl(m_ex);
    chk("pc_write", bus.pc_write_o, bus.start_i && !s);
    chk("stall", bus.stall_o, s);
    chk("flush", bus.flush_o, bus.id_branch_i && !s);
    chk("ifid_pc", bus.ifid_pc_o, m_ifid_pc);
    chk("ifid_instr", bus.ifid_instr_o, m_ifid);
    chk("ex_ctrl", bus.ex_ctrl_o, c);
    chk("fwd_a", bus.ex_fwd_a_o, m_fwd(f_rs1(m_ex)));
    chk("fwd_b", bus.ex_fwd_b_o, m_fwd(f_rs2(m_ex)));
    c = m_ctrl(m_mem);
    chk("mem_ctrl", bus.mem_ctrl_o, c[3:0]);
    chk("mem_rd", bus.mem_rd_o, f_rd(m_mem));
    c = m_ctrl(m_wb);
    chk("wb_regwrite", bus.wb_regwrite_o, c[1]);
    chk("wb_memtoreg", bus.wb_memtoreg_o, c[0]);
    chk("wb_rd", bus.wb_rd_o, f_rd(m_wb));
    chk("stall_cnt", bus.stall_cnt_o, m_scnt);
    chk("flush_cnt", bus.flush_cnt_o, m_fcnt);
  endtask

  task automatic set_in(input bit s, input logic [31:0] pc, input logic [31:0] ins, input bit br, input bit r);
    bus.start_i = s; bus.if_pc_i = pc; bus.if_instr_i = ins; bus.id_branch_i = br; rst = r;
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b1, '0, NOP, 1'b0, 1'b1);
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_instr();
    int rd, rs1, rs2;
    rd = $urandom_range(0, 3); rs1 = $urandom_range(0, 3); rs2 = $urandom_range(0, 3);
    case ($urandom_range(0, 5))
      0: return enc(7'h33, rd, rs1, rs2);
      1: return enc(7'h13, rd, rs1, rs2);
      2: return enc(7'h03, rd, rs1, rs2);
      3: return enc(7'h23, rd, rs1, rs2);
      4: return enc(7'h63, rd, rs1, rs2);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    set_in(1'b1, '0, NOP, 1'b0, 1'b1);
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    chk("rst_ex_ctrl", bus.ex_ctrl_o, 7'd0);
    chk("rst_ifid_instr", bus.ifid_instr_o, NOP);
    chk("rst_pc_write", bus.pc_write_o, 1'b1);

    // forward from EX/MEM on both operands
    do_reset();
    set_in(1'b1, 32'h4, enc(7'h13, 1, 0, 5), 1'b0, 1'b0); step();
    set_in(1'b1, 32'h8, enc(7'h33, 2, 1, 1), 1'b0, 1'b0); step();
    set_in(1'b1, 32'hc, NOP, 1'b0, 1'b0); step();
    chk("t1_fwd_a", bus.ex_fwd_a_o, 2'b10);
    chk("t1_fwd_b", bus.ex_fwd_b_o, 2'b10);

    // forward from MEM/WB; x0 never forwarded
    do_reset();
    set_in(1'b1, 32'h4, enc(7'h13, 1, 0, 5), 1'b0, 1'b0); step();
    set_in(1'b1, 32'h8, NOP, 1'b0, 1'b0); step();
    set_in(1'b1, 32'hc, enc(7'h33, 2, 1, 0), 1'b0, 1'b0); step();
    set_in(1'b1, 32'h10, NOP, 1'b0, 1'b0); step();
    chk("t2_fwd_a", bus.ex_fwd_a_o, 2'b01);
    chk("t2_fwd_b", bus.ex_fwd_b_o, 2'b00);

    // load-use stall
    do_reset();
    set_in(1'b1, 32'h4, enc(7'h03, 3, 0, 0), 1'b0, 1'b0); step();
    set_in(1'b1, 32'h8, enc(7'h33, 4, 3, 0), 1'b0, 1'b0); step();
    set_in(1'b1, 32'hc, NOP, 1'b0, 1'b0); #1;
    chk("t3_stall", bus.stall_o, 1'b1);
    chk("t3_pc_write", bus.pc_write_o, 1'b0);
    step();
    chk("t3_bubble", bus.ex_ctrl_o, 7'd0);
    step();
    chk("t3_fwd_a", bus.ex_fwd_a_o, 2'b01);
    chk("t3_stall_cnt", bus.stall_cnt_o, 16'd1);

    // taken branch flush
    do_reset();
    set_in(1'b1, 32'h4, enc(7'h63, 0, 1, 2), 1'b0, 1'b0); step();
    set_in(1'b1, 32'h40, enc(7'h33, 1, 2, 3), 1'b1, 1'b0); #1;
    chk("t4_flush", bus.flush_o, 1'b1);
    step();
    chk("t4_ifid_instr", bus.ifid_instr_o, NOP);
    chk("t4_ifid_pc", bus.ifid_pc_o, 32'h40);
    chk("t4_flush_cnt", bus.flush_cnt_o, 16'd1);

    // stall has priority over flush
    do_reset();
    set_in(1'b1, 32'h4, enc(7'h03, 5, 0, 0), 1'b0, 1'b0); step();
    set_in(1'b1, 32'h8, enc(7'h63, 0, 5, 0), 1'b0, 1'b0); step();
    set_in(1'b1, 32'h50, NOP, 1'b1, 1'b0); #1;
    chk("t5_flush_held", bus.flush_o, 1'b0);
    chk("t5_stall", bus.stall_o, 1'b1);
    step();
    chk("t5_flush", bus.flush_o, 1'b1);
    step();

    // start_i low freezes everything, then reset mid-stall
    do_reset();
    set_in(1'b1, 32'h4, enc(7'h03, 3, 0, 0), 1'b0, 1'b0); step();
    set_in(1'b1, 32'h8, enc(7'h33, 4, 3, 0), 1'b0, 1'b0); step();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, $urandom, rnd_instr(), 1'b0, 1'b0);
      step();
    end
    chk("t6_ifid_instr", bus.ifid_instr_o, enc(7'h33, 4, 3, 0));
    chk("t6_ex_ctrl", bus.ex_ctrl_o, 7'b1001011);
    chk("t6_stall_cnt", bus.stall_cnt_o, 16'd0);
    chk("t6_pc_write", bus.pc_write_o, 1'b0);
    do_reset();
    chk("t6_rst_ifid", bus.ifid_instr_o, NOP);
    chk("t6_rst_ex_ctrl", bus.ex_ctrl_o, 7'd0);
    chk("t6_rst_stall", bus.stall_o, 1'b0);

    for (int i = 0; i < 800; i++) begin
      set_in($urandom_range(0, 7) != 0, 32'(i * 4), rnd_instr(),
             $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0);
      step();
    end
    set_in(1'b1, '0, NOP, 1'b0, 1'b0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
